// File: rtl/nabp_mapper_pkg.sv
// Shared types and default widths for the NABP mapper sequencer.
package nabp_mapper_pkg;

  // Default field widths of the mapper datapath.
  localparam int unsigned KSLength       = 10;
  localparam int unsigned KAngleLength   = 8;
  localparam int unsigned KPeWidthLength = 5;

  // Sequencer states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/nabp_mapper_skid_fifo.sv
// Small circular FIFO that absorbs LUT results while the line buffer stalls.
module nabp_mapper_skid_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [Width-1:0]           wdata,
  input  logic                       pop,
  output logic [Width-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_q, wr_q;
  logic [CntW-1:0]  cnt_q;

  // Pointer increment with wrap at a possibly non-power-of-two depth.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Storage; contents need no reset because cnt_q gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= ptr_inc(wr_q);
      if (pop)  rd_q <= ptr_inc(rd_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

  // Upstream credit accounting must never let a push land on a full FIFO.
  assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (cnt_q == CntW'(Depth))));

endmodule

// File: rtl/nabp_mapper_seq.sv
// Sequencer for the NABP mapper LUT: sweeps angle/line addresses, tracks LUT latency with a
// tag pipeline and streams mapped S values to the line buffer through a credit-limited FIFO.
module nabp_mapper_seq
  import nabp_mapper_pkg::*;
#(
  parameter int unsigned LINE_LEN    = KPeWidthLength,
  parameter int unsigned ANGLE_LEN   = KAngleLength,
  parameter int unsigned S_LEN       = KSLength,
  parameter int unsigned NUM_LINES   = 32,
  parameter int unsigned ANGLE_STEP  = 1,
  parameter int unsigned ANGLE_LIMIT = 180,
  parameter int unsigned LUT_LAT     = 2,
  parameter int unsigned SKID_DEPTH  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [LINE_LEN-1:0]  mp_line_cnt,
  output logic [ANGLE_LEN-1:0] mp_angle,
  input  logic [S_LEN-1:0]     mp_s_val,
  output logic                 lb_valid,
  input  logic                 lb_ready,
  output logic [S_LEN-1:0]     lb_s_val,
  output logic [LINE_LEN-1:0]  lb_line_cnt,
  output logic [ANGLE_LEN-1:0] lb_angle,
  output logic                 lb_last_line,
  output logic                 lb_last_angle
);

  localparam int unsigned TagW = LINE_LEN + ANGLE_LEN + 2;
  localparam int unsigned EntW = S_LEN + TagW;
  localparam int unsigned CntW = $clog2(SKID_DEPTH + 1);
  localparam int unsigned OccW = $clog2(SKID_DEPTH + LUT_LAT + 1) + 1;

  state_e               state_q;
  logic [LINE_LEN-1:0]  line_q;
  logic [ANGLE_LEN-1:0] angle_q;
  logic [LUT_LAT-1:0]   tag_vld_q;
  logic [TagW-1:0]      tag_q [LUT_LAT];

  logic            issue;
  logic            is_last_line;
  logic            is_last_angle;
  logic            pop;
  logic            fifo_empty;
  logic            drain_done;
  logic [CntW-1:0] fifo_count;
  logic [OccW-1:0] inflight;
  logic [OccW-1:0] occupancy;
  logic [EntW-1:0] fifo_rdata;

  assign is_last_line  = (line_q == LINE_LEN'(NUM_LINES - 1));
  // Widened by one bit so the final angle is detected even if angle+step would wrap.
  assign is_last_angle = (({1'b0, angle_q} + (ANGLE_LEN+1)'(ANGLE_STEP))
                          >= (ANGLE_LEN+1)'(ANGLE_LIMIT));

  // Count lookups still travelling through the LUT.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LUT_LAT; i++) begin
      inflight = inflight + OccW'(tag_vld_q[i]);
    end
  end

  assign pop = lb_valid & lb_ready;
  // A pop this cycle frees a slot, so it is credited before deciding to issue.
  assign occupancy  = inflight + OccW'(fifo_count) - OccW'(pop);
  assign issue      = (state_q == StIssue) && (occupancy < OccW'(SKID_DEPTH));
  // Sweep finishes once nothing is in flight and the final beat leaves the FIFO this cycle.
  assign drain_done = (inflight == '0) &&
                      ((fifo_count == '0) || ((fifo_count == CntW'(1)) && pop));

  // Sequencer FSM and LUT address counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      line_q  <= '0;
      angle_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StIssue;
            line_q  <= '0;
            angle_q <= '0;
          end
        end
        StIssue: begin
          if (issue) begin
            if (is_last_line) begin
              line_q  <= '0;
              angle_q <= angle_q + ANGLE_LEN'(ANGLE_STEP);
              if (is_last_angle) state_q <= StDrain;
            end else begin
              line_q <= line_q + LINE_LEN'(1);
            end
          end
        end
        StDrain: begin
          if (drain_done) state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag shift register matching the LUT address-to-data latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld_q <= '0;
      for (int i = 0; i < LUT_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_vld_q[0] <= issue;
      tag_q[0]     <= {line_q, angle_q, is_last_line, is_last_angle};
      for (int i = 1; i < LUT_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_q[i]     <= tag_q[i-1];
      end
    end
  end

  nabp_mapper_skid_fifo #(
    .Width(EntW),
    .Depth(SKID_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (tag_vld_q[LUT_LAT-1]),
    .wdata({mp_s_val, tag_q[LUT_LAT-1]}),
    .pop  (pop),
    .rdata(fifo_rdata),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign {lb_s_val, lb_line_cnt, lb_angle, lb_last_line, lb_last_angle} = fifo_rdata;
  assign lb_valid    = !fifo_empty;
  assign busy        = (state_q == StIssue) || (state_q == StDrain);
  assign done        = (state_q == StDone);
  assign mp_line_cnt = line_q;
  assign mp_angle    = angle_q;

  assert property (@(posedge clk) disable iff (reset)
    (inflight + OccW'(fifo_count)) <= OccW'(SKID_DEPTH));

endmodule

// File: tb/tb_nabp_mapper_seq.sv
// Bench for nabp_mapper_seq: two instances (unit step sweep, 45-degree step sweep), LUT models,
// scoreboard queues checked on every accepted beat, plus directed corner-case sequences.
module tb_nabp_mapper_seq;

  localparam int unsigned NL = 4;

  typedef struct packed {
    logic [7:0] angle;
    logic [4:0] line;
    logic [9:0] s;
    logic       last_line;
    logic       last_angle;
  } beat_t;

  typedef struct {
    int    stall;
    beat_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic reset;
  logic a_start, a_busy, a_done, a_valid, a_ready, a_ll, a_la;
  logic [4:0] a_mp_line, a_line;
  logic [7:0] a_mp_angle, a_angle;
  logic [9:0] a_mp_s, a_s;
  logic b_start, b_busy, b_done, b_valid, b_ready, b_ll, b_la;
  logic [4:0] b_mp_line, b_line;
  logic [7:0] b_mp_angle, b_angle;
  logic [9:0] b_mp_s, b_s;

  nabp_mapper_seq #(
    .NUM_LINES(NL), .ANGLE_STEP(1), .ANGLE_LIMIT(4), .LUT_LAT(2), .SKID_DEPTH(3)
  ) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .busy(a_busy), .done(a_done),
    .mp_line_cnt(a_mp_line), .mp_angle(a_mp_angle), .mp_s_val(a_mp_s),
    .lb_valid(a_valid), .lb_ready(a_ready), .lb_s_val(a_s), .lb_line_cnt(a_line),
    .lb_angle(a_angle), .lb_last_line(a_ll), .lb_last_angle(a_la)
  );

  nabp_mapper_seq #(
    .NUM_LINES(NL), .ANGLE_STEP(45), .ANGLE_LIMIT(180), .LUT_LAT(2), .SKID_DEPTH(3)
  ) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
    .mp_line_cnt(b_mp_line), .mp_angle(b_mp_angle), .mp_s_val(b_mp_s),
    .lb_valid(b_valid), .lb_ready(b_ready), .lb_s_val(b_s), .lb_line_cnt(b_line),
    .lb_angle(b_angle), .lb_last_line(b_ll), .lb_last_angle(b_la)
  );

  // LUT models: two-stage registered ROM returning angle*NL+line.
  logic [9:0] a_lut1, a_lut2, b_lut1, b_lut2;
  always @(posedge clk) begin
    a_lut1 <= 10'(a_mp_angle * NL + a_mp_line);
    a_lut2 <= a_lut1;
    b_lut1 <= 10'(b_mp_angle * NL + b_mp_line);
    b_lut2 <= b_lut1;
  end
  assign a_mp_s = a_lut2;
  assign b_mp_s = b_lut2;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  beat_t exp_a[$];
  beat_t exp_b[$];
  beat_t tbl_a[16];
  vec_t  tbl_b[16];

  beat_t a_act, a_held;
  logic  a_hold_v = 1'b0;
  bit    b2b = 1'b0;
  int a_beats = 0, a_done_cnt = 0, a_last_cyc = -100, a_prev_cyc = -100;
  int b_beats = 0, b_done_cnt = 0, b_last_cyc = -100;

  // Monitor A: scoreboard, stall stability, back-to-back and done timing.
  always @(negedge clk) begin
    a_act = {a_angle, a_line, a_s, a_ll, a_la};
    if (reset) begin
      a_hold_v = 1'b0;
    end else begin
      if (a_hold_v) chk("a_stall_stable", a_act, a_held);
      if (a_valid && a_ready) begin
        chk("a_beat_expected", exp_a.size() > 0, 1);
        if (exp_a.size() > 0) chk("a_beat", a_act, exp_a.pop_front());
        if (b2b && a_beats > 0) chk("a_back_to_back", cyc - a_prev_cyc, 1);
        a_prev_cyc = cyc;
        a_beats++;
        if (a_ll && a_la) a_last_cyc = cyc;
      end
      if (a_done) begin
        a_done_cnt++;
        chk("a_done_timing", cyc - a_last_cyc, 1);
      end
      a_hold_v = a_valid && !a_ready;
      a_held   = a_act;
    end
  end

  // Monitor B: scoreboard and done timing.
  always @(negedge clk) begin
    if (!reset) begin
      if (b_valid && b_ready) begin
        chk("b_beat_expected", exp_b.size() > 0, 1);
        if (exp_b.size() > 0) chk("b_beat", {b_angle, b_line, b_s, b_ll, b_la}, exp_b.pop_front());
        b_beats++;
        if (b_ll && b_la) b_last_cyc = cyc;
      end
      if (b_done) begin
        b_done_cnt++;
        chk("b_done_timing", cyc - b_last_cyc, 1);
      end
    end
  end

  task automatic start_a();
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
  endtask

  task automatic push_a();
    for (int i = 0; i < 16; i++) exp_a.push_back(tbl_a[i]);
  endtask

  task automatic wait_a_done(input int target, input int budget);
    for (int k = 0; k < budget && a_done_cnt < target; k++) begin
      @(posedge clk); #1;
    end
    chk("a_done_count", a_done_cnt, target);
  endtask

  task automatic end_of_sweep_a(input string tag);
    chk({tag, "_beats"}, a_beats, 16);
    chk({tag, "_queue_empty"}, exp_a.size(), 0);
    @(negedge clk);
    chk({tag, "_idle_busy"}, a_busy, 0);
    chk({tag, "_idle_valid"}, a_valid, 0);
  endtask

  initial begin
    automatic int d0;
    automatic int b_angles[4] = '{0, 45, 90, 135};
    reset = 1'b1; a_start = 1'b0; b_start = 1'b0; a_ready = 1'b0; b_ready = 1'b0;

    for (int a = 0; a < 4; a++)
      for (int l = 0; l < NL; l++)
        tbl_a[a*NL+l] = '{angle: 8'(a), line: 5'(l), s: 10'(a*NL+l),
                          last_line: (l == NL-1), last_angle: (a == 3)};
    for (int i = 0; i < 16; i++) begin
      tbl_b[i].stall = i % 3;
      tbl_b[i].exp   = '{angle: 8'(b_angles[i/NL]), line: 5'(i % NL),
                         s: 10'(b_angles[i/NL]*NL + i%NL), last_line: ((i % NL) == NL-1),
                         last_angle: (b_angles[i/NL] == 135)};
    end

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_mp_line", a_mp_line, 0);
    chk("rst_mp_angle", a_mp_angle, 0);
    @(posedge clk); #1 reset = 1'b0;

    // 1: full sweep with ready held high, latency and back-to-back beats.
    a_ready = 1'b1; a_beats = 0; b2b = 1'b1; d0 = a_done_cnt;
    push_a();
    start_a();
    @(negedge clk); chk("t1_busy", a_busy, 1); chk("t1_lat1", a_valid, 0);
    @(negedge clk); chk("t1_lat2", a_valid, 0);
    @(negedge clk); chk("t1_lat3", a_valid, 0);
    @(negedge clk); chk("t1_first_valid", a_valid, 1);
    wait_a_done(d0 + 1, 100);
    b2b = 1'b0;
    end_of_sweep_a("t1");

    // 2: random ready across a full sweep.
    @(posedge clk); #1 a_beats = 0; d0 = a_done_cnt;
    push_a();
    start_a();
    for (int k = 0; k < 400 && a_done_cnt == d0; k++) begin
      @(posedge clk); #1 a_ready = 1'($urandom_range(0, 1));
    end
    chk("t2_done_count", a_done_cnt, d0 + 1);
    end_of_sweep_a("t2");

    // 3: ready low after start stops issue after three lookups.
    @(posedge clk); #1 a_ready = 1'b0; a_beats = 0; d0 = a_done_cnt;
    push_a();
    start_a();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t3_issued_line", a_mp_line, 3);
    chk("t3_issued_angle", a_mp_angle, 0);
    chk("t3_valid", a_valid, 1);
    repeat (10) @(negedge clk);
    chk("t3_still_stopped", a_mp_line, 3);
    @(posedge clk); #1 a_ready = 1'b1;
    wait_a_done(d0 + 1, 100);
    end_of_sweep_a("t3");

    // 5: reset at beat 7, then a clean sweep.
    @(posedge clk); #1 a_beats = 0;
    push_a();
    start_a();
    for (int k = 0; k < 100 && a_beats < 7; k++) begin
      @(posedge clk); #1;
    end
    chk("t5_reached_beat7", a_beats, 7);
    reset = 1'b1; d0 = a_done_cnt;
    @(posedge clk);
    @(negedge clk);
    chk("t5_valid_after_reset", a_valid, 0);
    chk("t5_busy_after_reset", a_busy, 0);
    @(posedge clk); #1 reset = 1'b0;
    exp_a.delete();
    repeat (10) @(posedge clk);
    #1 chk("t5_no_done", a_done_cnt, d0);
    a_beats = 0;
    push_a();
    start_a();
    wait_a_done(d0 + 1, 100);
    end_of_sweep_a("t5");

    // 6: start with reset high, and a second start while busy, are both ignored.
    @(posedge clk); #1 reset = 1'b1; a_start = 1'b1;
    @(posedge clk); #1 reset = 1'b0; a_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_reset_start_ignored", a_busy, 0);
    a_beats = 0; d0 = a_done_cnt;
    push_a();
    start_a();
    repeat (4) @(posedge clk);
    #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    wait_a_done(d0 + 1, 100);
    repeat (20) @(posedge clk);
    #1 chk("t6_single_done", a_done_cnt, d0 + 1);
    end_of_sweep_a("t6");

    // 4: 45-degree steps, per-beat stall pattern from the vector table.
    b_beats = 0;
    for (int i = 0; i < 16; i++) exp_b.push_back(tbl_b[i].exp);
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b_ready = 1'b0;
      repeat (tbl_b[i].stall) begin
        @(posedge clk); #1;
      end
      b_ready = 1'b1;
      for (int k = 0; k < 50 && b_beats <= i; k++) begin
        @(posedge clk); #1;
      end
    end
    b_ready = 1'b0;
    for (int k = 0; k < 20 && b_done_cnt == 0; k++) begin
      @(posedge clk); #1;
    end
    chk("t4_beats", b_beats, 16);
    chk("t4_queue_empty", exp_b.size(), 0);
    chk("t4_done_count", b_done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish (got timeout, required completion)");
    $fatal(1);
  end

endmodule
